// File: rtl/store_pkg.sv
// store_pkg: shared store-width codes, strobe width and the store-buffer entry layout.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int STRB_W  = 4;
    localparam int WADDR_W = 30;

    typedef logic [WADDR_W-1:0] waddr_t;

    typedef struct packed {
        waddr_t            waddr;
        logic [31:0]       wdata;
        logic [STRB_W-1:0] wstrb;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// store_align: turns a raw SB/SH/SW request into lane-replicated data, byte strobes and legality flags.
module store_align
    import store_pkg::*;
(
    input  logic [2:0]        func3,
    input  logic [1:0]        addr,
    input  logic [31:0]       data,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              aligned,
    output logic              legal
);

    always_comb begin
        legal   = func3 inside {F3_SB, F3_SH, F3_SW};
        aligned = (func3 == F3_SB)
               || (func3 == F3_SH && !addr[0])
               || (func3 == F3_SW && addr == 2'b00);
        wstrb   = func3 == F3_SB ? 4'b0001 << addr
                : func3 == F3_SH ? (addr[1] ? 4'b1100 : 4'b0011)
                : func3 == F3_SW ? 4'b1111
                : 4'b0000;
        wdata   = func3 == F3_SB ? {4{data[7:0]}}
                : func3 == F3_SH ? {2{data[15:0]}}
                : data;
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of aligned stores draining to the data RAM,
// with a word-granular load-hit flag and a registered fault pulse.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              me_store_valid,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [31:0]       me_store_data,
    input  logic [2:0]        me_func3_code,
    input  logic              me_load_valid,
    input  logic [ADDR_W-1:0] me_load_addr,
    output logic              sb_full,
    output logic              sb_empty,
    output logic              sb_load_hit,
    output logic              sb_fault,
    output logic              dmem_we,
    output logic [ADDR_W-3:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WA = ADDR_W - 2;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              sb_fault_q, sb_fault_d;
    sb_entry_t         mem_q [DEPTH];
    sb_entry_t         new_entry, head;
    logic [31:0]       al_wdata;
    logic [STRB_W-1:0] al_wstrb;
    logic              aligned, legal, enq, deq;
    logic [PW-1:0]     offs [DEPTH];
    logic [DEPTH-1:0]  hit_vec;
    logic [1:0]        unused_load_lo;

    store_align u_align (
        .func3   (me_func3_code),
        .addr    (me_addr[1:0]),
        .data    (me_store_data),
        .wdata   (al_wdata),
        .wstrb   (al_wstrb),
        .aligned (aligned),
        .legal   (legal)
    );

    assign unused_load_lo = me_load_addr[1:0];

    always_comb begin
        sb_full         = count_q == CW'(DEPTH);
        sb_empty        = count_q == '0;
        dmem_we         = !sb_empty;
        head            = mem_q[rd_ptr_q];
        dmem_addr       = WA'(head.waddr);
        dmem_wdata      = head.wdata;
        dmem_wstrb      = head.wstrb;
        sb_fault        = sb_fault_q;
        // sb_full is taken from the registered count, so a dequeue never frees room for this cycle's store
        enq             = me_store_valid && !sb_full && aligned && legal;
        deq             = dmem_we && dmem_ready;
        wr_ptr_d        = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d        = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d         = count_q + CW'(enq) - CW'(deq);
        sb_fault_d      = me_store_valid && !(aligned && legal);
        new_entry.waddr = waddr_t'(me_addr[ADDR_W-1:2]);
        new_entry.wdata = al_wdata;
        new_entry.wstrb = al_wstrb;
        sb_load_hit     = me_load_valid && |hit_vec;
    end

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hit
        assign offs[g]    = PW'(g) - rd_ptr_q;
        assign hit_vec[g] = ({1'b0, offs[g]} < count_q)
                         && (mem_q[g].waddr == waddr_t'(me_load_addr[ADDR_W-1:2]));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sb_fault_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sb_fault_q <= sb_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem_q[wr_ptr_q] <= new_entry;
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed plus random stimulus checked each cycle against a queue-based store model.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          me_store_valid = 1'b0;
    logic [AW-1:0] me_addr = '0;
    logic [31:0]   me_store_data = '0;
    logic [2:0]    me_func3_code = '0;
    logic          me_load_valid = 1'b0;
    logic [AW-1:0] me_load_addr = '0;
    logic          dmem_ready = 1'b0;
    logic          sb_full, sb_empty, sb_load_hit, sb_fault, dmem_we;
    logic [AW-3:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_wstrb;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .me_store_valid (me_store_valid),
        .me_addr        (me_addr),
        .me_store_data  (me_store_data),
        .me_func3_code  (me_func3_code),
        .me_load_valid  (me_load_valid),
        .me_load_addr   (me_load_addr),
        .sb_full        (sb_full),
        .sb_empty       (sb_empty),
        .sb_load_hit    (sb_load_hit),
        .sb_fault       (sb_fault),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_ready     (dmem_ready)
    );

    typedef struct {
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
    } ent_t;

    ent_t q[$];
    logic exp_fault = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    function automatic int nbytes(logic [2:0] f);
        return f == 3'd0 ? 1 : f == 3'd1 ? 2 : f == 3'd2 ? 4 : 0;
    endfunction

    function automatic logic model_hit();
        if (!me_load_valid) return 1'b0;
        foreach (q[i]) if (q[i].wa == me_load_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("empty", 32'(sb_empty), 32'(q.size() == 0));
        chk("full", 32'(sb_full), 32'(q.size() == DEPTH));
        chk("we", 32'(dmem_we), 32'(q.size() != 0));
        chk("fault", 32'(sb_fault), 32'(exp_fault));
        chk("hit", 32'(sb_load_hit), 32'(model_hit()));
        if (q.size() != 0) begin
            chk("addr", 32'(dmem_addr), 32'(q[0].wa));
            chk("wdata", dmem_wdata, q[0].wd);
            chk("wstrb", 32'(dmem_wstrb), 32'(q[0].ws));
        end
    endtask

    // Model the edge from the byte-lane rules: width n bytes at offset a.
    task automatic model_edge();
        int   n, a;
        bit   ok, full;
        ent_t e;
        n = nbytes(me_func3_code);
        a = int'(me_addr[1:0]);
        ok = (n == 0) ? 1'b0 : ((a % n) == 0);
        if (!rstn) begin
            q.delete();
            exp_fault = 1'b0;
            return;
        end
        full = q.size() == DEPTH;
        exp_fault = me_store_valid && !ok;
        if (q.size() != 0 && dmem_ready) void'(q.pop_front());
        if (me_store_valid && ok && !full) begin
            e.wa = me_addr[31:2];
            e.ws = '0;
            e.wd = '0;
            for (int k = 0; k < 4; k++) begin
                if (k >= a && k < a + n) e.ws[k] = 1'b1;
                e.wd[8*k +: 8] = me_store_data[8*(k % n) +: 8];
            end
            q.push_back(e);
        end
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic store(logic [2:0] f, logic [31:0] a, logic [31:0] d);
        me_store_valid = 1'b1;
        me_func3_code  = f;
        me_addr        = a;
        me_store_data  = d;
    endtask

    task automatic idle();
        me_store_valid = 1'b0;
        me_load_valid  = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_full", 32'(sb_full), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_fault", 32'(sb_fault), 32'd0);
        chk("rst_hit", 32'(sb_load_hit), 32'd0);

        dmem_ready = 1'b1;
        store(3'b000, 32'h103, 32'h0000_00A5);
        tick();
        idle();
        #1;
        chk("t1_we", 32'(dmem_we), 32'd1);
        chk("t1_addr", 32'(dmem_addr), 32'h40);
        chk("t1_wstrb", 32'(dmem_wstrb), 32'b1000);
        chk("t1_wdata", dmem_wdata, 32'hA5A5_A5A5);
        tick();
        #1 chk("t1_drained", 32'(sb_empty), 32'd1);

        dmem_ready = 1'b0;
        store(3'b001, 32'h202, 32'h1234_BEEF);
        tick();
        store(3'b010, 32'h204, 32'hCAFE_F00D);
        tick();
        idle();
        tick();
        chk("t2_hold_strb", 32'(dmem_wstrb), 32'b1100);
        chk("t2_hold_data", dmem_wdata, 32'hBEEF_BEEF);
        dmem_ready = 1'b1;
        tick();
        chk("t2_sw_strb", 32'(dmem_wstrb), 32'b1111);
        chk("t2_sw_data", dmem_wdata, 32'hCAFE_F00D);
        tick();
        #1 chk("t2_empty", 32'(sb_empty), 32'd1);

        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(3'b010, 32'h500 + 32'(4*i), 32'h1000 + 32'(i));
            tick();
        end
        #1 chk("t3_full", 32'(sb_full), 32'd1);
        store(3'b010, 32'h520, 32'hDEAD_0005);
        tick();
        chk("t3_refused_head", 32'(dmem_addr), 32'h140);
        dmem_ready = 1'b1;
        store(3'b010, 32'h524, 32'hDEAD_0006);
        tick();
        chk("t3_count3", 32'(sb_full), 32'd0);
        tick();
        idle();
        repeat (5) tick();

        store(3'b010, 32'h302, 32'h1);
        tick();
        idle();
        chk("t4_sw_fault", 32'(sb_fault), 32'd1);
        tick();
        chk("t4_fault_clear", 32'(sb_fault), 32'd0);
        store(3'b001, 32'h301, 32'h2);
        tick();
        chk("t4_sh_fault", 32'(sb_fault), 32'd1);
        store(3'b011, 32'h300, 32'h3);
        tick();
        idle();
        chk("t4_f3_fault", 32'(sb_fault), 32'd1);
        chk("t4_no_enq", 32'(sb_empty), 32'd1);
        tick();

        dmem_ready = 1'b0;
        store(3'b010, 32'h400, 32'h4);
        tick();
        idle();
        me_load_valid = 1'b1;
        me_load_addr  = 32'h403;
        #1 chk("t5_hit", 32'(sb_load_hit), 32'd1);
        me_load_addr  = 32'h404;
        #1 chk("t5_miss", 32'(sb_load_hit), 32'd0);
        dmem_ready = 1'b1;
        tick();
        me_load_addr  = 32'h403;
        #1 chk("t5_drained_miss", 32'(sb_load_hit), 32'd0);
        idle();

        dmem_ready = 1'b0;
        store(3'b010, 32'h600, 32'h6);
        tick();
        store(3'b000, 32'h605, 32'h7);
        tick();
        idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("t6_empty", 32'(sb_empty), 32'd1);
        chk("t6_we", 32'(dmem_we), 32'd0);
        chk("t6_fault", 32'(sb_fault), 32'd0);
        repeat (3) tick();

        for (int c = 0; c < 400; c++) begin
            rstn           = ($urandom_range(0, 59) != 0);
            me_store_valid = $urandom_range(0, 2) != 0;
            me_func3_code  = ($urandom_range(0, 7) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            me_addr        = 32'h800 + 32'($urandom_range(0, 31));
            me_store_data  = $urandom;
            me_load_valid  = $urandom_range(0, 1) != 0;
            me_load_addr   = 32'h800 + 32'($urandom_range(0, 31));
            dmem_ready     = $urandom_range(0, 2) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-direction counterpart of the memory-to-writeback load return path.
- Accepts SB/SH/SW requests from the MEM stage, aligns them into byte lanes with strobes, and queues them in a small FIFO.
- Drains the FIFO to the synchronous data RAM under a ready handshake.
- Flags loads that hit a pending store so the hazard unit can stall the load until that store drains.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2
ADDR_W, 32, byte-address width from the MEM stage

Ports:
clk  in  1  clock; all state updates on the rising edge
rstn  in  1  reset, synchronous, active-low
me_store_valid  in  1  MEM stage presents a store this cycle
me_addr  in  ADDR_W  store byte address (ALU result)
me_store_data  in  32  rs2 value, unaligned
me_func3_code  in  3  store width: 000 SB, 001 SH, 010 SW
me_load_valid  in  1  MEM stage presents a load this cycle
me_load_addr  in  ADDR_W  load byte address
sb_full  out  1  combinational; count == DEPTH; MEM stage must stall any store
sb_empty  out  1  combinational; count == 0; used for fence/drain
sb_load_hit  out  1  combinational; load word address matches any valid entry
sb_fault  out  1  registered one-cycle pulse on a misaligned or illegal store
dmem_we  out  1  head entry valid (equals !sb_empty)
dmem_addr  out  ADDR_W-2  head word address (byte address [ADDR_W-1:2])
dmem_wdata  out  32  head lane-replicated data
dmem_wstrb  out  4  head byte strobes
dmem_ready  in  1  RAM accepts the head this cycle

Behaviour:
- Reset (rstn low at posedge clk):
  - write pointer, read pointer and count go to 0; sb_fault goes to 0.
  - Outputs: sb_empty 1, sb_full 0, dmem_we 0, sb_load_hit 0.
  - Entry payloads are not reset; dmem_addr, dmem_wdata and dmem_wstrb are don't-care while dmem_we is 0.
  - Reset mid-drain discards all pending entries.
- Enqueue:
  - Condition: me_store_valid && !sb_full && aligned && legal func3.
  - The entry is written at the write pointer and the pointer increments mod DEPTH.
- Alignment (combinational, ahead of the FIFO), with a = me_addr[1:0]:
  - SB: wstrb = 4'b0001 << a; wdata = byte 0 of me_store_data replicated ×4; always aligned.
  - SH: a[0] must be 0; wstrb = a[1] ? 4'b1100 : 4'b0011; wdata = low halfword replicated ×2.
  - SW: a must be 00; wstrb = 4'b1111; wdata = me_store_data.
- Fault:
  - A misaligned SH/SW, or func3 not in {000, 001, 010}, with me_store_valid high: no enqueue, and sb_fault = 1 on the next cycle only.
  - A faulting store while full: not enqueued, fault still reported.
- Dequeue:
  - Condition: dmem_we && dmem_ready; the read pointer increments mod DEPTH.
  - Head fields remain stable while dmem_ready is low.
- Latency: a store enqueued at edge N is presented on dmem_* from cycle N+1 when the FIFO was empty.
- Simultaneous enqueue and dequeue:
  - Not full: both occur and count is unchanged.
  - Full: enqueue is refused because sb_full is computed before the dequeue; the dequeue still happens.
  - Empty: an incoming store is not bypassed to dmem_* in the same cycle.
- Count: ceil(log2(DEPTH))+1 bits. Pointers wrap naturally at DEPTH.
- Load hazard:
  - sb_load_hit = me_load_valid && OR over valid entries of (entry word addr == me_load_addr[ADDR_W-1:2]).
  - Word granularity is used; there is no byte-level forwarding.
  - The entry being dequeued in the current cycle still counts as a hit.
- Order: stores reach RAM strictly in program order; no merging or coalescing.

Decomposition:
- Package store_pkg:
  - constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010
  - STRB_W=4
  - typedef for an entry struct {word addr, wdata[31:0], wstrb[3:0]}
- One combinational sub-module, store_align:
  - inputs: func3, addr[1:0], data
  - outputs: wdata, wstrb, aligned, legal
- The FIFO, pointers, hit comparators and fault register live in store_buffer.

Test Plan:
1. Reset, then SB addr 0x103, data 0x000000A5, dmem_ready=1
   -> next cycle dmem_we=1, dmem_addr=0x40, wstrb=4'b1000, wdata=0xA5A5A5A5; sb_empty=1 one cycle later.
2. SH at 0x202 data 0x1234BEEF, then SW at 0x204 data 0xCAFEF00D, dmem_ready=0
   -> head stays wstrb=1100 / wdata=0xBEEFBEEF.
   Raise dmem_ready for 2 cycles -> second write wstrb=1111, wdata=0xCAFEF00D, then sb_empty=1.
3. With dmem_ready=0, issue 4 SW stores -> sb_full=1; a 5th store is not enqueued.
   With dmem_ready=1 and a 6th store asserted in the same cycle -> it is refused (count goes 4->3); it enqueues on the following cycle.
4. SW at 0x302 -> no enqueue, sb_fault=1 for exactly one cycle.
   SH at 0x301 and func3=011 -> same result; count unchanged.
5. Pending SW at 0x400, load at 0x403 -> sb_load_hit=1.
   Load at 0x404 -> 0.
   After the entry drains -> load at 0x403 gives 0.
6. Two entries pending, rstn low for one edge -> sb_empty=1, dmem_we=0, sb_fault=0; no further RAM writes occur.
